// File: rtl/seven_bit_adder_load_ctrl.sv
// Button sequencer for the 7-bit adder. It debounces PB1..PB4 and assembles operands A and B from nibble Y.
// It then captures the external adder's sum and carry once the final operand part is loaded.
module seven_bit_adder_load_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       PB1,
    input  logic       PB2,
    input  logic       PB3,
    input  logic       PB4,
    input  logic [3:0] Y,
    output logic [6:0] op_a,
    output logic [6:0] op_b,
    input  logic [6:0] add_sum,
    input  logic       add_carry,
    output logic [6:0] z,
    output logic       carry,
    output logic       valid,
    output logic       seq_err,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_WAIT_A_LO = 3'd0,
        S_WAIT_A_HI = 3'd1,
        S_WAIT_B_LO = 3'd2,
        S_WAIT_B_HI = 3'd3,
        S_ADD       = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [3:0]       w_raw;
    logic [CNT_W-1:0] r_cnt [4];
    logic [3:0]       r_lvl;
    logic [3:0]       r_lvl_q;
    logic [3:0]       w_evt;
    logic             w_any_hi;
    logic             w_multi;

    state_t     r_state, w_state_nxt;
    logic [6:0] r_op_a, w_op_a_nxt;
    logic [6:0] r_op_b, w_op_b_nxt;
    logic [6:0] r_z, w_z_nxt;
    logic       r_carry, w_carry_nxt;
    logic       r_valid, w_valid_nxt;
    logic       r_seq_err, w_seq_err_nxt;

    assign w_raw = {PB4, PB3, PB2, PB1};

    // Level rises on the edge where the counter reaches its limit; the event is its rising edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
            r_lvl   <= '0;
            r_lvl_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!w_raw[i]) begin
                    r_cnt[i] <= '0;
                    r_lvl[i] <= 1'b0;
                end else if (r_cnt[i] != LP_CNT_MAX) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                    if (r_cnt[i] + 1'b1 == LP_CNT_MAX) r_lvl[i] <= 1'b1;
                end
            end
            r_lvl_q <= r_lvl;
        end
    end

    assign w_evt    = r_lvl & ~r_lvl_q;
    assign w_any_hi = |w_evt[3:1];
    assign w_multi  = (w_evt[1] & w_evt[2]) | (w_evt[1] & w_evt[3]) | (w_evt[2] & w_evt[3]);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_WAIT_A_LO;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_z       <= '0;
            r_carry   <= 1'b0;
            r_valid   <= 1'b0;
            r_seq_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_op_a    <= w_op_a_nxt;
            r_op_b    <= w_op_b_nxt;
            r_z       <= w_z_nxt;
            r_carry   <= w_carry_nxt;
            r_valid   <= w_valid_nxt;
            r_seq_err <= w_seq_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_op_a_nxt    = r_op_a;
        w_op_b_nxt    = r_op_b;
        w_z_nxt       = r_z;
        w_carry_nxt   = r_carry;
        w_valid_nxt   = r_valid;
        w_seq_err_nxt = r_seq_err;
        if (w_evt[0]) begin
            w_op_a_nxt[3:0] = Y;
            w_valid_nxt     = 1'b0;
            w_seq_err_nxt   = 1'b0;
            w_state_nxt     = S_WAIT_A_HI;
        end else begin
            case (r_state)
                S_WAIT_A_LO: if (w_any_hi) w_seq_err_nxt = 1'b1;
                S_WAIT_A_HI: begin
                    if (w_multi || w_evt[2] || w_evt[3]) w_seq_err_nxt = 1'b1;
                    else if (w_evt[1]) begin
                        w_op_a_nxt[6:4] = Y[2:0];
                        w_state_nxt     = S_WAIT_B_LO;
                    end
                end
                S_WAIT_B_LO: begin
                    if (w_multi || w_evt[1] || w_evt[3]) w_seq_err_nxt = 1'b1;
                    else if (w_evt[2]) begin
                        w_op_b_nxt[3:0] = Y;
                        w_state_nxt     = S_WAIT_B_HI;
                    end
                end
                S_WAIT_B_HI: begin
                    if (w_multi || w_evt[1] || w_evt[2]) w_seq_err_nxt = 1'b1;
                    else if (w_evt[3]) begin
                        w_op_b_nxt[6:4] = Y[2:0];
                        w_state_nxt     = S_ADD;
                    end
                end
                S_ADD: begin
                    w_z_nxt     = add_sum;
                    w_carry_nxt = add_carry;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = S_DONE;
                    if (w_any_hi) w_seq_err_nxt = 1'b1;
                end
                S_DONE: if (w_any_hi) w_seq_err_nxt = 1'b1;
                default: w_state_nxt = S_WAIT_A_LO;
            endcase
        end
    end

    assign op_a    = r_op_a;
    assign op_b    = r_op_b;
    assign z       = r_z;
    assign carry   = r_carry;
    assign valid   = r_valid;
    assign seq_err = r_seq_err;
    assign state   = r_state;

endmodule

// File: tb/tb_seven_bit_adder_load_ctrl.sv
// Directed bench for seven_bit_adder_load_ctrl. Expected output snapshots are queued as each step is driven.
// They are popped and compared at negedge sample points.
module tb_seven_bit_adder_load_ctrl;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [3:0] pb = '0;
    logic [3:0] y = '0;
    logic [6:0] op_a, op_b, add_sum, z;
    logic       add_carry, carry, valid, seq_err;
    logic [2:0] state;

    int n_chk = 0;
    int n_err = 0;

    // packed snapshot: {op_a, op_b, z, carry, valid, seq_err, state}
    logic [26:0] exp_q[$];

    always #5 clk = ~clk;

    // external 7-bit adder datapath
    assign {add_carry, add_sum} = {1'b0, op_a} + {1'b0, op_b};

    seven_bit_adder_load_ctrl #(.DEBOUNCE_CYCLES(DB), .CNT_W(3)) dut (
        .clk(clk), .rstn(rstn),
        .PB1(pb[0]), .PB2(pb[1]), .PB3(pb[2]), .PB4(pb[3]),
        .Y(y), .op_a(op_a), .op_b(op_b),
        .add_sum(add_sum), .add_carry(add_carry),
        .z(z), .carry(carry), .valid(valid), .seq_err(seq_err), .state(state)
    );

    task automatic push_exp(input logic [6:0] a, input logic [6:0] b, input logic [6:0] ez,
                            input logic ec, input logic ev, input logic ee, input logic [2:0] es);
        exp_q.push_back({a, b, ez, ec, ev, ee, es});
    endtask

    task automatic cmp(input string tag, input string fld, input logic [6:0] got, input logic [6:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s.%s: got %b expected %b", tag, fld, got, exp);
        end
    endtask

    task automatic check(input string tag);
        logic [26:0] e;
        if (exp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $error("FAIL %s.queue: got empty expected entry", tag);
        end else begin
            e = exp_q.pop_front();
            cmp(tag, "op_a",    op_a,            e[26:20]);
            cmp(tag, "op_b",    op_b,            e[19:13]);
            cmp(tag, "z",       z,               e[12:6]);
            cmp(tag, "carry",   {6'd0, carry},   {6'd0, e[5]});
            cmp(tag, "valid",   {6'd0, valid},   {6'd0, e[4]});
            cmp(tag, "seq_err", {6'd0, seq_err}, {6'd0, e[3]});
            cmp(tag, "state",   {4'd0, state},   {4'd0, e[2:0]});
        end
    endtask

    // Raise the given buttons with data y for hold cycles, then release and let the FSM settle.
    task automatic press(input logic [3:0] btns, input logic [3:0] yv, input int hold);
        @(negedge clk);
        y  = yv;
        pb = btns;
        repeat (hold) @(negedge clk);
        pb = '0;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        do_reset();
        push_exp(7'b0, 7'b0, 7'b0, 0, 0, 0, 3'd0);
        check("reset");

        // full sequence
        press(4'b0001, 4'b1101, DB + 4);
        push_exp(7'b0001101, 7'b0, 7'b0, 0, 0, 0, 3'd1);
        check("t1_pb1");
        press(4'b0010, 4'b0110, DB + 4);
        push_exp(7'b1101101, 7'b0, 7'b0, 0, 0, 0, 3'd2);
        check("t1_pb2");
        press(4'b0100, 4'b1110, DB + 4);
        push_exp(7'b1101101, 7'b0001110, 7'b0, 0, 0, 0, 3'd3);
        check("t1_pb3");
        press(4'b1000, 4'b0101, DB + 4);
        push_exp(7'b1101101, 7'b1011110, 7'b1001011, 1, 1, 0, 3'd5);
        check("t1_result");

        // out-of-order press in DONE: sticky error, outputs held
        press(4'b0100, 4'b0000, DB + 4);
        push_exp(7'b1101101, 7'b1011110, 7'b1001011, 1, 1, 1, 3'd5);
        check("done_pb3");

        // restart from DONE
        press(4'b0001, 4'b0001, DB + 4);
        push_exp(7'b1100001, 7'b1011110, 7'b1001011, 1, 0, 0, 3'd1);
        check("t5_restart");

        // short glitch on PB2 is ignored
        press(4'b0010, 4'b0111, DB - 1);
        push_exp(7'b1100001, 7'b1011110, 7'b1001011, 1, 0, 0, 3'd1);
        check("t2_glitch");

        // two simultaneous events are out-of-order even if one is expected
        press(4'b0110, 4'b0000, DB + 4);
        push_exp(7'b1100001, 7'b1011110, 7'b1001011, 1, 0, 1, 3'd1);
        check("multi_evt");
        press(4'b0001, 4'b0001, DB + 4);
        push_exp(7'b1100001, 7'b1011110, 7'b1001011, 1, 0, 0, 3'd1);
        check("pb1_clear");

        // Y[3] ignored on high load
        press(4'b0010, 4'b1000, DB + 4);
        push_exp(7'b0000001, 7'b1011110, 7'b1001011, 1, 0, 0, 3'd2);
        check("t5_pb2");

        // long hold gives one load; Y changes after the load must not be taken
        @(negedge clk);
        y  = 4'b1111;
        pb = 4'b0100;
        repeat (20) @(negedge clk);
        y = 4'b0000;
        repeat (30) @(negedge clk);
        pb = '0;
        repeat (4) @(negedge clk);
        push_exp(7'b0000001, 7'b1011111, 7'b1001011, 1, 0, 0, 3'd3);
        check("t3_hold");

        // 1 + 127 wraps to 0 with carry
        press(4'b1000, 4'b1111, DB + 4);
        push_exp(7'b0000001, 7'b1111111, 7'b0000000, 1, 1, 0, 3'd5);
        check("t5_wrap");

        // out-of-order from reset, then recovery
        do_reset();
        press(4'b0100, 4'b1010, DB + 4);
        push_exp(7'b0, 7'b0, 7'b0, 0, 0, 1, 3'd0);
        check("t4_err");
        press(4'b0001, 4'b0000, DB + 4);
        push_exp(7'b0, 7'b0, 7'b0, 0, 0, 0, 3'd1);
        check("t4_recover");

        // asynchronous reset in WAIT_B_HI
        press(4'b0010, 4'b0001, DB + 4);
        press(4'b0100, 4'b0011, DB + 4);
        push_exp(7'b0010000, 7'b0000011, 7'b0, 0, 0, 0, 3'd3);
        check("t6_pre");
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        push_exp(7'b0, 7'b0, 7'b0, 0, 0, 0, 3'd0);
        check("t6_async_rst");
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
